// File: rtl/dsm_cic_decimator.sv
// dsm_cic_decimator: 3-level pwm decode, 3rd-order CIC decimation by DECIM, valid/ready output.
module dsm_cic_decimator #(
    parameter int DECIM = 50,
    parameter int ACC_W = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       pwm,
    output logic [ACC_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             code_err,
    output logic             overrun
);
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DECIM - 1);

    logic [ACC_W-1:0] x, c1, c2, c3;
    logic [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic [ACC_W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [ACC_W-1:0] dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d, code_err_q, code_err_d, overrun_q, overrun_d;
    logic             strobe;

    // wrap-around in every sum is intentional; the comb stage cancels it
    always_comb begin
        x          = (pwm == 2'b01) ? ACC_W'(1) : (pwm == 2'b11) ? '1 : '0;
        strobe     = cnt_q == CNT_MAX;
        i1_d       = i1_q + x;
        i2_d       = i2_q + i1_q;
        i3_d       = i3_q + i2_q;
        c1         = i3_q - d1_q;
        c2         = c1 - d2_q;
        c3         = c2 - d3_q;
        d1_d       = strobe ? i3_q : d1_q;
        d2_d       = strobe ? c1 : d2_q;
        d3_d       = strobe ? c2 : d3_q;
        cnt_d      = strobe ? '0 : cnt_q + CNT_W'(1);
        dout_d     = strobe ? c3 : dout_q;
        valid_d    = strobe | (valid_q & ~dout_ready);
        code_err_d = code_err_q | (pwm == 2'b10);
        overrun_d  = overrun_q | (strobe & valid_q & ~dout_ready);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i1_q       <= '0;
            i2_q       <= '0;
            i3_q       <= '0;
            d1_q       <= '0;
            d2_q       <= '0;
            d3_q       <= '0;
            cnt_q      <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            code_err_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            i1_q       <= i1_d;
            i2_q       <= i2_d;
            i3_q       <= i3_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            d3_q       <= d3_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            code_err_q <= code_err_d;
            overrun_q  <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign code_err   = code_err_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_dsm_cic_decimator.sv
// tb_dsm_cic_decimator: random and directed stimulus checked against a triple-boxcar convolution model.
module tb_dsm_cic_decimator;
    localparam int DECIM = 50;
    localparam int ACC_W = 20;
    localparam int HLEN  = 3 * DECIM - 2;

    logic             clock, reset, dout_valid, dout_ready, code_err, overrun;
    logic [1:0]       pwm;
    logic [ACC_W-1:0] dout;

    dsm_cic_decimator #(.DECIM(DECIM), .ACC_W(ACC_W)) dut (
        .clock(clock), .reset(reset), .pwm(pwm), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .code_err(code_err), .overrun(overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int mode   = 1;
    int rmode  = 1;
    int ph     = 0;
    bit inj    = 0;
    bit chk_en = 0;
    int h[HLEN];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // impulse response of three cascaded length-DECIM boxcar sums
    initial begin
        int b2[2*DECIM-1];
        foreach (b2[n]) b2[n] = 0;
        foreach (h[n]) h[n] = 0;
        for (int a = 0; a < DECIM; a++)
            for (int b = 0; b < DECIM; b++) b2[a+b]++;
        for (int a = 0; a < DECIM; a++)
            for (int n = 0; n < 2*DECIM-1; n++) h[a+n] += b2[n];
    end

    int               xs[$];
    int               t;
    logic [ACC_W-1:0] m_dout;
    logic             m_valid, m_err, m_ovr;

    function automatic logic [ACC_W-1:0] model_sample(input int tc);
        longint acc = 0;
        for (int k = 0; k < HLEN; k++)
            if (tc - 3 - k >= 0) acc += longint'(h[k]) * longint'(xs[tc-3-k]);
        return ACC_W'(acc);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            xs.delete();
            t = 0;
            m_dout = '0; m_valid = 0; m_err = 0; m_ovr = 0;
        end else begin
            xs.push_back(pwm == 2'b01 ? 1 : pwm == 2'b11 ? -1 : 0);
            m_err = m_err | (pwm == 2'b10);
            if (t % DECIM == DECIM - 1) begin
                m_ovr   = m_ovr | (m_valid & ~dout_ready);
                m_dout  = model_sample(t);
                m_valid = 1;
            end else if (m_valid && dout_ready) m_valid = 0;
            t++;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("dout", 32'(dout), 32'(m_dout));
            chk("dout_valid", 32'(dout_valid), 32'(m_valid));
            chk("code_err", 32'(code_err), 32'(m_err));
            chk("overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    always @(negedge clock) begin
        int r;
        #1;
        r = $urandom_range(0, 99);
        pwm = (mode == 0) ? 2'b00 : (mode == 1) ? 2'b01 : (mode == 2) ? 2'b11 :
              (mode == 3) ? (ph[0] ? 2'b11 : 2'b01) : (mode == 4) ? (ph[0] ? 2'b00 : 2'b01) :
              (r < 2) ? 2'b10 : (r < 40) ? 2'b01 : (r < 75) ? 2'b11 : 2'b00;
        if (inj) begin
            pwm = 2'b10;
            inj = 0;
        end
        ph++;
        if (rmode == 2) dout_ready = 1'($urandom_range(0, 1));
    end

    task automatic expect_sample(input string nm, input logic [ACC_W-1:0] lit);
        int k;
        for (k = 0; k < 2 * DECIM; k++) begin
            @(negedge clock);
            if (dout_valid) break;
        end
        chk({nm, "_wait"}, 32'(k < 2 * DECIM), 32'd1);
        chk(nm, 32'(dout), 32'(lit));
        chk({nm, "_model"}, 32'(m_dout), 32'(lit));
    endtask

    task automatic pulse_reset();
        @(negedge clock); #2 reset = 0;
        repeat (3) @(negedge clock);
        #2 reset = 1;
    endtask

    function automatic int latency_dummy(); return 0; endfunction

    initial begin
        int lat;
        reset = 1; dout_ready = 1; pwm = 2'b00;
        #3 reset = 0;
        chk_en = 1;
        @(negedge clock);
        chk("reset_dout", 32'(dout), 32'd0);
        chk("reset_valid", 32'(dout_valid), 32'd0);
        repeat (2) @(negedge clock);
        #2 reset = 1;

        mode = 1; repeat (300) @(negedge clock);
        expect_sample("const_pos", 20'd125000);
        chk("const_pos_err", 32'(code_err), 32'd0);
        chk("const_pos_ovr", 32'(overrun), 32'd0);

        mode = 2; repeat (250) @(negedge clock);
        expect_sample("const_neg", 20'hE17B8);
        mode = 3; repeat (250) @(negedge clock);
        expect_sample("alternate", 20'd0);
        mode = 4; repeat (250) @(negedge clock);
        expect_sample("half_duty", 20'd62500);
        mode = 0; repeat (250) @(negedge clock);
        expect_sample("const_zero", 20'd0);

        mode = 1; repeat (250) @(negedge clock);
        expect_sample("settle_pos", 20'd125000);
        repeat (2) @(negedge clock);
        #2 rmode = 0; dout_ready = 0;
        expect_sample("stall_first", 20'd125000);
        chk("stall_first_ovr", 32'(overrun), 32'd0);
        repeat (DECIM) @(negedge clock);
        chk("stall_second_ovr", 32'(overrun), 32'd1);
        chk("stall_second_valid", 32'(dout_valid), 32'd1);

        #2 rmode = 1; dout_ready = 1; mode = 0;
        repeat (250) @(negedge clock);
        @(negedge clock); #2 inj = 1;
        @(negedge clock); @(negedge clock);
        chk("code_err_set", 32'(code_err), 32'd1);
        expect_sample("code_err_zero", 20'd0);
        chk("code_err_sticky", 32'(code_err), 32'd1);

        mode = 1;
        pulse_reset();
        repeat (270) @(negedge clock);
        #2 reset = 0;
        @(negedge clock);
        chk("midreset_dout", 32'(dout), 32'd0);
        chk("midreset_flags", 32'({dout_valid, code_err, overrun}), 32'd0);
        repeat (2) @(negedge clock);
        #2 reset = 1;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (dout_valid) begin
                lat = k;
                break;
            end
        end
        chk("reset_latency", 32'(lat), 32'd50);
        repeat (150) @(negedge clock);
        expect_sample("post_reset_pos", 20'd125000);

        rmode = 0; dout_ready = 0;
        pulse_reset();
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (dout_valid) begin
                lat = k;
                break;
            end
        end
        chk("stall_latency", 32'(lat), 32'd50);
        chk("stall_ovr0", 32'(overrun), 32'd0);
        repeat (DECIM - 1) @(negedge clock);
        #2 dout_ready = 1;
        @(negedge clock);
        chk("ready_at_strobe_valid", 32'(dout_valid), 32'd1);
        chk("ready_at_strobe_ovr", 32'(overrun), 32'd0);
        #2 dout_ready = 0;
        repeat (DECIM) @(negedge clock);
        chk("stall_ovr1", 32'(overrun), 32'd1);

        mode = 5; rmode = 2;
        pulse_reset();
        repeat (2000) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
